// File: rtl/lcd_timing_gen.sv
// RGB-panel raster timing generator: waits for a settled PLL lock, then emits
// hsync/vsync/de, pixel coordinates and a frame-start pulse.
module lcd_timing_gen #(
  parameter int unsigned H_ACTIVE      = 800,
  parameter int unsigned H_FP          = 40,
  parameter int unsigned H_SYNC        = 128,
  parameter int unsigned H_BP          = 88,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FP          = 1,
  parameter int unsigned V_SYNC        = 3,
  parameter int unsigned V_BP          = 21,
  parameter bit          HS_POL        = 1'b0,
  parameter bit          VS_POL        = 1'b0,
  parameter int unsigned SETTLE_CYCLES = 1024
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        lock,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic        frame_start,
  output logic        running
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CW      = 12;
  // Region bounds compared at 13 bits so a bound of exactly 4096 stays representable.
  localparam int unsigned BW      = CW + 1;
  // The IDLE->SETTLE clock is the first lock-high clock, so SETTLE counts the rest.
  localparam int unsigned SW      = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES >= 2) ? (SETTLE_CYCLES - 2) : 0);
  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [BW-1:0] H_ACT_END   = BW'(H_ACTIVE);
  localparam logic [BW-1:0] H_SYNC_BEG  = BW'(H_ACTIVE + H_FP);
  localparam logic [BW-1:0] H_SYNC_END  = BW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [BW-1:0] V_ACT_END   = BW'(V_ACTIVE);
  localparam logic [BW-1:0] V_SYNC_BEG  = BW'(V_ACTIVE + V_FP);
  localparam logic [BW-1:0] V_SYNC_END  = BW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t          state;
  logic            lock_meta;
  logic            lock_s;
  logic [SW-1:0]   settle_cnt;
  logic [CW-1:0]   h_cnt;
  logic [CW-1:0]   v_cnt;

  logic            active;
  logic            h_act;
  logic            v_act;
  logic            h_in_sync;
  logic            v_in_sync;

  // Two-flop synchronizer bringing the PLL lock into the pixel clock domain.
  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= lock;
      lock_s    <= lock_meta;
    end
  end

  // Lock-settle state machine with the raster counters it owns.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          h_cnt      <= '0;
          v_cnt      <= '0;
          settle_cnt <= '0;
          if (lock_s) begin
            state <= (SETTLE_CYCLES > 1) ? ST_SETTLE : ST_RUN;
          end
        end
        ST_SETTLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (!lock_s) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= ST_RUN;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state <= ST_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
          end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
          end else begin
            h_cnt <= h_cnt + 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          settle_cnt <= '0;
          h_cnt      <= '0;
          v_cnt      <= '0;
        end
      endcase
    end
  end

  // Region decode of the current counters; outputs go idle on the RUN exit clock.
  always_comb begin
    active    = (state == ST_RUN) && lock_s;
    h_act     = {1'b0, h_cnt} < H_ACT_END;
    v_act     = {1'b0, v_cnt} < V_ACT_END;
    h_in_sync = ({1'b0, h_cnt} >= H_SYNC_BEG) && ({1'b0, h_cnt} < H_SYNC_END);
    v_in_sync = ({1'b0, v_cnt} >= V_SYNC_BEG) && ({1'b0, v_cnt} < V_SYNC_END);
  end

  // Registered panel outputs, one clock behind the counters.
  always_ff @(posedge clkin) begin
    if (reset || !active) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      hsync       <= h_in_sync ? HS_POL : ~HS_POL;
      vsync       <= v_in_sync ? VS_POL : ~VS_POL;
      de          <= h_act && v_act;
      pixel_x     <= (h_act && v_act) ? h_cnt : '0;
      pixel_y     <= (h_act && v_act) ? v_cnt : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      running     <= 1'b1;
    end
  end

endmodule
